// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------
// cpu_pkg: shared register indices, As encodings, constant-generator values
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int REG_PC  = 0;
  localparam int REG_SP  = 1;
  localparam int REG_SR  = 2;
  localparam int REG_CG2 = 3;

  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;

  // Signed ints so a DW'() cast sign-extends CG_M1 to all ones at any width
  localparam int CG_0  = 0;
  localparam int CG_1  = 1;
  localparam int CG_2  = 2;
  localparam int CG_4  = 4;
  localparam int CG_8  = 8;
  localparam int CG_M1 = -1;

endpackage

`default_nettype wire

// File: rtl/reg_file_param_cg_mux.sv
// ---------------------------------------------------------------
// cg_mux: constant-generator aware source read ({As, SA, regs[SA]} -> Sout)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module cg_mux
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic [1:0]    As,
  input  logic [AW-1:0] SA,
  input  logic [DW-1:0] sa_data,
  output logic [DW-1:0] cg_out
);

  always_comb begin
    cg_out = sa_data;
    if (SA == AW'(REG_SR)) begin
      case (As)
        AS_IDX:  cg_out = DW'(CG_0);
        AS_IND:  cg_out = DW'(CG_4);
        AS_INC:  cg_out = DW'(CG_8);
        default: cg_out = sa_data;
      endcase
    end else if (SA == AW'(REG_CG2)) begin
      case (As)
        AS_REG:  cg_out = DW'(CG_0);
        AS_IDX:  cg_out = DW'(CG_1);
        AS_IND:  cg_out = DW'(CG_2);
        default: cg_out = DW'(CG_M1);
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------
// reg_file_param: NREGS x DW register file with PC/SP/SR ports and R2/R3
// constant generator; optional same-cycle forwarding via REG_FILE_BYPASS_EN.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module reg_file_param
  import cpu_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RW,
  input  logic          BW,
  input  logic [1:0]    As,
  input  logic [AW-1:0] SA,
  input  logic [AW-1:0] DA,
  input  logic [DW-1:0] Din,
  input  logic [DW-1:0] reg_PC_in,
  input  logic          PC_we,
  input  logic [DW-1:0] reg_SP_in,
  input  logic          SP_we,
  input  logic [DW-1:0] reg_SR_in,
  input  logic          SR_we,
  output logic [DW-1:0] reg_PC_out,
  output logic [DW-1:0] reg_SP_out,
  output logic [DW-1:0] reg_SR_out,
  output logic [DW-1:0] Sout,
  output logic [DW-1:0] Dout
);

  localparam logic [DW-1:0] LSB_CLR = {{(DW-1){1'b1}}, 1'b0};

  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] wdata;
  logic [DW-1:0] sout_raw;

  assign wdata = BW ? {{(DW-8){1'b0}}, Din[7:0]} : Din;

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == REG_CG2) begin : g_cg2
      assign regs[i] = '0;
    end else begin : g_store
      // PC keeps bit 0 clear no matter which port writes it
      localparam logic [DW-1:0] KEEP = (i == REG_PC) ? LSB_CLR : '1;
      logic [DW-1:0] q;
      logic          ded_we;
      logic [DW-1:0] ded_d;

      if (i == REG_PC) begin : g_pc
        assign ded_we = PC_we;
        assign ded_d  = reg_PC_in;
      end else if (i == REG_SP) begin : g_sp
        assign ded_we = SP_we;
        assign ded_d  = reg_SP_in;
      end else if (i == REG_SR) begin : g_sr
        assign ded_we = SR_we;
        assign ded_d  = reg_SR_in;
      end else begin : g_gen
        assign ded_we = 1'b0;
        assign ded_d  = '0;
      end

      always_ff @(posedge clk) begin
        if (rst)                           q <= '0;
        else if (RW && (DA == AW'(i)))     q <= wdata & KEEP;
        else if (ded_we)                   q <= ded_d & KEEP;
      end

      assign regs[i] = q;
    end
  end

  assign reg_PC_out = regs[REG_PC];
  assign reg_SP_out = regs[REG_SP];
  assign reg_SR_out = regs[REG_SR];

  cg_mux #(.DW(DW), .AW(AW)) u_cg_mux (
    .As      (As),
    .SA      (SA),
    .sa_data (regs[SA]),
    .cg_out  (sout_raw)
  );

`ifdef REG_FILE_BYPASS_EN
  logic [DW-1:0] fwd_data;
  logic          d_fwd;
  logic          s_fwd;

  assign fwd_data = (DA == AW'(REG_PC)) ? (wdata & LSB_CLR) : wdata;
  assign d_fwd    = RW && (DA != AW'(REG_CG2));
  // A selected R2 constant wins over forwarding
  assign s_fwd    = d_fwd && (SA == DA) && !((SA == AW'(REG_SR)) && (As != AS_REG));
  assign Sout     = s_fwd ? fwd_data : sout_raw;
  assign Dout     = d_fwd ? fwd_data : regs[DA];
`else
  assign Sout = sout_raw;
  assign Dout = regs[DA];
`endif

endmodule

`default_nettype wire
